// File: rtl/sky_load_store_unit_if.sv
// -----------------------------------------------------------------------------
// sky_load_store_unit_if
//   Bundles the execute-side request/response handshake and the data-memory
//   bus of the load/store unit.
//
//   slave  : the load/store unit itself
//   master : execute stage, writeback and data memory (the unit's environment)
//
//   Request  : req_valid/req_ready, req_write, req_size, req_signed, req_addr,
//              req_wdata, req_rd
//   Response : rsp_valid, rsp_reg_write, rsp_rd, rsp_data, rsp_fault, rsp_cause
//   Memory   : mem_address, mem_read_en, mem_write_en, mem_write_data,
//              mem_read_data
//   Stall    : busy
// -----------------------------------------------------------------------------
interface sky_load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_rd;

    logic        rsp_valid;
    logic        rsp_reg_write;
    logic [3:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic [1:0]  rsp_cause;

    logic [31:0] mem_address;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic        busy;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd,
        input  mem_read_data,
        output req_ready, busy,
        output rsp_valid, rsp_reg_write, rsp_rd, rsp_data, rsp_fault, rsp_cause,
        output mem_address, mem_read_en, mem_write_en, mem_write_data
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, req_rd,
        output mem_read_data,
        input  req_ready, busy,
        input  rsp_valid, rsp_reg_write, rsp_rd, rsp_data, rsp_fault, rsp_cause,
        input  mem_address, mem_read_en, mem_write_en, mem_write_data
    );
endinterface

// File: rtl/sky_load_store_unit.sv
// -----------------------------------------------------------------------------
// sky_load_store_unit
//   Load/store unit between execute and a single-port, word-wide data memory
//   with a one-cycle registered read and full-word writes. One request is in
//   flight at a time. Loads extract a little-endian byte/half/word lane with
//   sign or zero extension; sub-word stores are read-modify-write. Faulting
//   requests (bad size, out of range, misaligned) never touch memory and are
//   answered the cycle after acceptance.
//
//   Ports:
//     clk    : clock, all state on the rising edge
//     reset  : asynchronous, active-low
//     io_lsu : sky_load_store_unit_if.slave (request, response, memory, busy)
//
//   Response latency after acceptance at cycle T:
//     fault T+1, word store T+2, load T+3, sub-word store T+4
// -----------------------------------------------------------------------------
module sky_load_store_unit #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    sky_load_store_unit_if.slave  io_lsu
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        LDATA
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_RANGE    = 2'b10,
        CAUSE_SIZE     = 2'b11
    } cause_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    // Request context captured at acceptance
    state_t      r_state;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_write;
    logic [15:0] r_wdata;      // only the sub-word store path needs it
    logic [3:0]  r_rd;

    // Registered outputs
    logic        r_rsp_valid;
    logic        r_rsp_reg_write;
    logic [3:0]  r_rsp_rd;
    logic [31:0] r_rsp_data;
    logic        r_rsp_fault;
    cause_t      r_rsp_cause;
    logic [31:0] r_mem_address;
    logic        r_mem_read_en;
    logic        r_mem_write_en;
    logic [31:0] r_mem_write_data;   // doubles as the RMW merge register

    logic        w_ready;
    logic        w_accept;
    cause_t      w_cause;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    // Ready is gated by reset directly so it drops in the same cycle reset
    // asserts, not one edge later.
    assign w_ready  = (r_state == IDLE) && reset;
    assign w_accept = io_lsu.req_valid && w_ready;

    // Fault classification of the incoming request; size beats range beats
    // alignment.
    always_comb begin
        // NOTE: assign a default before any branching so every path drives the
        // signal; a missing path in combinational logic infers a latch.
        w_cause = CAUSE_NONE;
        if (io_lsu.req_size == SIZE_BAD) begin
            w_cause = CAUSE_SIZE;
        end else if (io_lsu.req_addr >= MEM_BYTES) begin
            w_cause = CAUSE_RANGE;
        end else if ((io_lsu.req_size == SIZE_HALF && io_lsu.req_addr[0]) ||
                     (io_lsu.req_size == SIZE_WORD && io_lsu.req_addr[1:0] != 2'b00)) begin
            w_cause = CAUSE_MISALIGN;
        end
    end

    // Load lane extraction and extension from the word returned by memory.
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = io_lsu.mem_read_data[7:0];
            2'd1:    w_byte = io_lsu.mem_read_data[15:8];
            2'd2:    w_byte = io_lsu.mem_read_data[23:16];
            default: w_byte = io_lsu.mem_read_data[31:24];
        endcase
        w_half = r_lane[1] ? io_lsu.mem_read_data[31:16] : io_lsu.mem_read_data[15:0];
        case (r_size)
            SIZE_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default:   w_load_data = io_lsu.mem_read_data;   // word ignores signedness
        endcase
    end

    // Sub-word store merge: overwrite only the addressed lane of the old word.
    always_comb begin
        w_merge_data = io_lsu.mem_read_data;
        if (r_size == SIZE_HALF) begin
            if (r_lane[1]) w_merge_data[31:16] = r_wdata;
            else           w_merge_data[15:0]  = r_wdata;
        end else begin
            case (r_lane)
                2'd0:    w_merge_data[7:0]   = r_wdata[7:0];
                2'd1:    w_merge_data[15:8]  = r_wdata[7:0];
                2'd2:    w_merge_data[23:16] = r_wdata[7:0];
                default: w_merge_data[31:24] = r_wdata[7:0];
            endcase
        end
    end

    // Control FSM with all outputs registered. Strobes and rsp_valid default
    // low every cycle so each is a single-cycle pulse in its own state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_lane           <= 2'b00;
            r_size           <= SIZE_BYTE;
            r_signed         <= 1'b0;
            r_write          <= 1'b0;
            r_wdata          <= '0;
            r_rd             <= '0;
            r_rsp_valid      <= 1'b0;
            r_rsp_reg_write  <= 1'b0;
            r_rsp_rd         <= '0;
            r_rsp_data       <= '0;
            r_rsp_fault      <= 1'b0;
            r_rsp_cause      <= CAUSE_NONE;
            r_mem_address    <= '0;
            r_mem_read_en    <= 1'b0;
            r_mem_write_en   <= 1'b0;
            r_mem_write_data <= '0;
        end else begin
            r_rsp_valid    <= 1'b0;
            r_mem_read_en  <= 1'b0;
            r_mem_write_en <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_lane   <= io_lsu.req_addr[1:0];
                        r_size   <= io_lsu.req_size;
                        r_signed <= io_lsu.req_signed;
                        r_write  <= io_lsu.req_write;
                        r_wdata  <= io_lsu.req_wdata[15:0];
                        r_rd     <= io_lsu.req_rd;

                        if (w_cause != CAUSE_NONE) begin
                            // Rejected: answer now, leave the memory bus alone.
                            r_rsp_valid     <= 1'b1;
                            r_rsp_reg_write <= 1'b0;
                            r_rsp_rd        <= io_lsu.req_rd;
                            r_rsp_data      <= '0;
                            r_rsp_fault     <= 1'b1;
                            r_rsp_cause     <= w_cause;
                        end else begin
                            r_mem_address <= {io_lsu.req_addr[31:2], 2'b00};
                            if (io_lsu.req_write && io_lsu.req_size == SIZE_WORD) begin
                                r_state          <= WRITE;
                                r_mem_write_en   <= 1'b1;
                                r_mem_write_data <= io_lsu.req_wdata;
                            end else begin
                                // Loads and sub-word stores both need the old word.
                                r_state       <= READ;
                                r_mem_read_en <= 1'b1;
                            end
                        end
                    end
                end

                READ: begin
                    r_state <= r_write ? MERGE : LDATA;
                end

                MERGE: begin
                    r_mem_write_data <= w_merge_data;
                    r_mem_write_en   <= 1'b1;
                    r_state          <= WRITE;
                end

                WRITE: begin
                    r_rsp_valid     <= 1'b1;
                    r_rsp_reg_write <= 1'b0;
                    r_rsp_rd        <= r_rd;
                    r_rsp_data      <= '0;
                    r_rsp_fault     <= 1'b0;
                    r_rsp_cause     <= CAUSE_NONE;
                    r_state         <= IDLE;
                end

                LDATA: begin
                    r_rsp_valid     <= 1'b1;
                    r_rsp_reg_write <= 1'b1;
                    r_rsp_rd        <= r_rd;
                    r_rsp_data      <= w_load_data;
                    r_rsp_fault     <= 1'b0;
                    r_rsp_cause     <= CAUSE_NONE;
                    r_state         <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_lsu.req_ready      = w_ready;
    assign io_lsu.busy           = ~w_ready;
    assign io_lsu.rsp_valid      = r_rsp_valid;
    assign io_lsu.rsp_reg_write  = r_rsp_reg_write;
    assign io_lsu.rsp_rd         = r_rsp_rd;
    assign io_lsu.rsp_data       = r_rsp_data;
    assign io_lsu.rsp_fault      = r_rsp_fault;
    assign io_lsu.rsp_cause      = r_rsp_cause;
    assign io_lsu.mem_address    = r_mem_address;
    assign io_lsu.mem_read_en    = r_mem_read_en;
    assign io_lsu.mem_write_en   = r_mem_write_en;
    assign io_lsu.mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_sky_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_sky_load_store_unit
//   Drives sky_load_store_unit through its interface, emulates the data memory,
//   and compares every response against a word-array reference model that
//   computes results with plain shifts and masks.
// -----------------------------------------------------------------------------
module tb_sky_load_store_unit;

    localparam int unsigned MEM_BYTES = 4096;
    localparam int unsigned WORDS     = MEM_BYTES / 4;

    logic clk;
    logic reset;
    logic load_mem;

    sky_load_store_unit_if bus ();

    sky_load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_lsu (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: registered read, full-word write.
    logic [31:0] dmem    [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < int'(WORDS); i++) dmem[i] <= ref_mem[i];
        end else begin
            if (bus.mem_write_en) dmem[bus.mem_address[11:2]] <= bus.mem_write_data;
            if (bus.mem_read_en)  bus.mem_read_data <= dmem[bus.mem_address[11:2]];
        end
    end

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: expected response and strobe counts; updates ref_mem.
    task automatic model_apply(input logic wr, input logic [1:0] sz, input logic sg,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output int lat, output logic [31:0] data,
                               output logic regwr, output logic [1:0] cause,
                               output int n_re, output int n_we, output int we_cyc);
        int unsigned idx;
        int unsigned sh;
        logic [31:0] w;
        logic [31:0] mask;
        cause = 2'd0;
        if (sz == 2'd3)                                                 cause = 2'd3;
        else if (addr >= MEM_BYTES)                                      cause = 2'd2;
        else if ((sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0)) cause = 2'd1;
        data = 32'd0; regwr = 1'b0; n_re = 0; n_we = 0; we_cyc = 0; lat = 1;
        if (cause == 2'd0) begin
            idx = addr / 4;
            w   = ref_mem[idx];
            sh  = (addr % 4) * 8;
            if (!wr) begin
                n_re = 1; lat = 3; regwr = 1'b1;
                if (sz == 2'd0) begin
                    data = (w >> sh) & 32'hFF;
                    if (sg && data >= 32'd128) data = data | 32'hFFFF_FF00;
                end else if (sz == 2'd1) begin
                    data = (w >> sh) & 32'hFFFF;
                    if (sg && data >= 32'd32768) data = data | 32'hFFFF_0000;
                end else begin
                    data = w;
                end
            end else if (sz == 2'd2) begin
                n_we = 1; we_cyc = 1; lat = 2;
                ref_mem[idx] = wdata;
            end else begin
                n_re = 1; n_we = 1; we_cyc = 3; lat = 4;
                mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
                ref_mem[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
            end
        end
    endtask

    // One complete request: drive, wait for acceptance, collect the response.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] rd, output logic [31:0] got_data);
        int          e_lat, e_re, e_we, e_we_cyc;
        logic [31:0] e_data;
        logic        e_regwr;
        logic [1:0]  e_cause;
        int          lat, n_re, n_we, re_cyc, we_cyc, guard;
        logic        g_regwr, g_fault;
        logic [1:0]  g_cause;
        logic [3:0]  g_rd;

        model_apply(wr, sz, sg, addr, wdata, e_lat, e_data, e_regwr, e_cause, e_re, e_we, e_we_cyc);

        @(negedge clk);
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        bus.req_valid  = 1'b1;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        lat = 0; n_re = 0; n_we = 0; re_cyc = 0; we_cyc = 0;
        got_data = 32'd0; g_regwr = 1'b0; g_fault = 1'b0; g_cause = 2'd0; g_rd = 4'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.mem_read_en)  begin n_re++; if (re_cyc == 0) re_cyc = c; end
            if (bus.mem_write_en) begin n_we++; if (we_cyc == 0) we_cyc = c; end
            if (bus.rsp_valid) begin
                lat      = c;
                got_data = bus.rsp_data;
                g_regwr  = bus.rsp_reg_write;
                g_fault  = bus.rsp_fault;
                g_cause  = bus.rsp_cause;
                g_rd     = bus.rsp_rd;
                break;
            end
        end
        check("rsp_latency",   32'(lat),     32'(e_lat));
        check("rsp_data",      got_data,     e_data);
        check("rsp_reg_write", 32'(g_regwr), 32'(e_regwr));
        check("rsp_fault",     32'(g_fault), 32'(e_cause != 2'd0));
        check("rsp_cause",     32'(g_cause), 32'(e_cause));
        check("rsp_rd",        32'(g_rd),    32'(rd));
        check("read_strobes",  32'(n_re),    32'(e_re));
        check("write_strobes", 32'(n_we),    32'(e_we));
        check("read_cycle",    32'(re_cyc),  32'(e_re));
        check("write_cycle",   32'(we_cyc),  32'(e_we_cyc));
        @(negedge clk);
        check("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] e1_data, e2_data;
        logic        e_rw;
        logic [1:0]  e_c;
        int          e_lat, e_re, e_we, e_wc, lat2;
        int          pulses, writes;

        reset          = 1'b0;
        load_mem       = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_rd     = 4'd0;
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = $urandom;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready",     32'(bus.req_ready),    32'd0);
        check("rst_busy",      32'(bus.busy),         32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid),    32'd0);
        check("rst_read_en",   32'(bus.mem_read_en),  32'd0);
        check("rst_write_en",  32'(bus.mem_write_en), 32'd0);
        check("rst_address",   bus.mem_address,       32'd0);
        check("rst_rsp_data",  bus.rsp_data,          32'd0);
        load_mem = 1'b0;
        reset    = 1'b1;
        #1;
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_busy",  32'(bus.busy),      32'd0);

        // Word store then load
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'd1, got);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         4'd3, got);
        check("word_load", got, 32'hDEAD_BEEF);

        // Sub-word read-modify-write
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 4'd0, got);
        issue(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA, 4'd0, got);
        check("rmw_byte", dmem[8], 32'h11AA_3344);
        issue(1'b1, 2'd1, 1'b0, 32'h20, 32'h0000_BEEF, 4'd0, got);
        check("rmw_half", dmem[8], 32'h11AA_BEEF);

        // Extension
        issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF_7F01, 4'd0, got);
        issue(1'b0, 2'd0, 1'b1, 32'h31, 32'h0, 4'd4, got);
        check("ext_sbyte_31", got, 32'h0000_007F);
        issue(1'b0, 2'd0, 1'b1, 32'h32, 32'h0, 4'd4, got);
        check("ext_sbyte_32", got, 32'hFFFF_FFFF);
        issue(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 4'd4, got);
        check("ext_uhalf_32", got, 32'h0000_80FF);
        issue(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 4'd4, got);
        check("ext_shalf_32", got, 32'hFFFF_80FF);

        // Faults (latency, zero data and strobe counts checked inside issue)
        issue(1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0, 4'd7, got);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 4'd8, got);
        issue(1'b1, 2'd3, 1'b0, 32'h0000_2001, 32'h1234, 4'd9, got);

        // Back-to-back loads with req_valid held
        model_apply(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_lat, e1_data, e_rw, e_c, e_re, e_we, e_wc);
        model_apply(1'b0, 2'd0, 1'b1, 32'h31, 32'h0, e_lat, e2_data, e_rw, e_c, e_re, e_we, e_wc);
        @(negedge clk);
        bus.req_write = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
        bus.req_addr  = 32'h10; bus.req_rd = 4'd5; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_size = 2'd0; bus.req_signed = 1'b1; bus.req_addr = 32'h31; bus.req_rd = 4'd6;
        @(negedge clk);
        check("b2b_read_ready", 32'(bus.req_ready),   32'd0);
        check("b2b_read_busy",  32'(bus.busy),        32'd1);
        check("b2b_read_en",    32'(bus.mem_read_en), 32'd1);
        @(negedge clk);
        check("b2b_ldata_busy",  32'(bus.busy),      32'd1);
        check("b2b_ldata_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("b2b_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b_rsp1_data",  bus.rsp_data,       e1_data);
        check("b2b_rsp1_rd",    32'(bus.rsp_rd),    32'd5);
        check("b2b_rsp1_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat2 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat2 = c;
                check("b2b_rsp2_data", bus.rsp_data,    e2_data);
                check("b2b_rsp2_rd",   32'(bus.rsp_rd), 32'd6);
                break;
            end
        end
        check("b2b_rsp2_latency", 32'(lat2), 32'd3);
        @(negedge clk);

        // Reset in the middle of a sub-word store
        issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, 4'd0, got);
        @(negedge clk);
        bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_signed = 1'b0;
        bus.req_addr  = 32'h40; bus.req_wdata = 32'h55; bus.req_rd = 4'd2; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_read_en", 32'(bus.mem_read_en), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid),    32'd0);
        check("mid_rst_ready",     32'(bus.req_ready),    32'd0);
        check("mid_rst_busy",      32'(bus.busy),         32'd1);
        check("mid_rst_read_en",   32'(bus.mem_read_en),  32'd0);
        check("mid_rst_write_en",  32'(bus.mem_write_en), 32'd0);
        check("mid_rst_address",   bus.mem_address,       32'd0);
        check("mid_rst_wdata",     bus.mem_write_data,    32'd0);
        check("mid_rst_cause",     32'(bus.rsp_cause),    32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulses = 0; writes = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid)    pulses++;
            if (bus.mem_write_en) writes++;
        end
        check("mid_rst_no_rsp",   32'(pulses), 32'd0);
        check("mid_rst_no_write", 32'(writes), 32'd0);
        check("mid_rst_mem",      dmem[16],    32'hCAFE_F00D);

        // Randomized traffic against the reference model
        for (int n = 0; n < 250; n++) begin
            logic        wr, sg;
            logic [1:0]  sz;
            logic [31:0] addr;
            int unsigned r;
            wr = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r  = $urandom_range(0, 9);
            if (r == 0)      addr = MEM_BYTES + $urandom_range(0, 10000);
            else if (r == 1) addr = $urandom;
            else             addr = $urandom_range(0, 127);
            issue(wr, sz, sg, addr, $urandom, 4'($urandom_range(0, 15)), got);
        end

        // Final memory image
        for (int i = 0; i < int'(WORDS); i++) check("mem_image", dmem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
